// File: rtl/mux_81_tx_if.sv
// Parallel-in / serial-out link between a word source and a 1:8 select-driven demux.
// The source side is master (start/din/pause); the transmitter is slave.
interface mux_81_tx_if;
  logic       start;
  logic [7:0] din;
  logic       pause;
  logic       d_out;
  logic [2:0] s_out;
  logic       valid;
  logic       busy;
  logic       done;

  modport master (output start, din, pause,
                  input  d_out, s_out, valid, busy, done);
  modport slave  (input  start, din, pause,
                  output d_out, s_out, valid, busy, done);
endinterface

// File: rtl/mux_81_tx.sv
// Transmit side of the 1-to-8 select/data link: captures a byte on start and sends
// one bit per slot, each held SLOT_CYCLES unpaused cycles, with the slot index as select.
module mux_81_tx #(
  parameter int SLOT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_81_tx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(SLOT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] frame_q, frame_d;
  logic [2:0] slot_q,  slot_d;
  logic [7:0] dwell_q, dwell_d;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    slot_d  = slot_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          frame_d = bus.din;
          slot_d  = 3'd0;
          dwell_d = 8'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        // pause freezes both counters so the slot resumes with its remaining dwell
        if (!bus.pause) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = 8'd0;
            if (slot_q == 3'd7) state_d = DONE;
            else                slot_d  = slot_q + 3'd1;
          end else begin
            dwell_d = dwell_q + 8'd1;
          end
        end
      end
      DONE: begin
        slot_d  = 3'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= 8'd0;
      slot_q  <= 3'd0;
      dwell_q <= 8'd0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      slot_q  <= slot_d;
      dwell_q <= dwell_d;
    end
  end

  // valid follows pause combinationally so a frozen slot is never counted twice downstream
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.valid = (state_q == SEND) && !bus.pause;
  assign bus.s_out = (state_q == IDLE) ? 3'd0 : slot_q;
  assign bus.d_out = (state_q == SEND) ? frame_q[slot_q] : 1'b0;

endmodule
